ped_crossing_ctrl: RTL and testbench

//  Pedestrian-signal stage downstream of the vehicle traffic light controller; consumes its red/yellow/green outputs.

---
 rtl/ped_crossing_ctrl.sv | 118 +++++++++++
 tb/tb_ped_crossing_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ped_crossing_ctrl.sv
// ped_crossing_ctrl: pedestrian WALK/DONT_WALK sequencer slaved to the vehicle light controller
module ped_crossing_ctrl #(
  parameter int WALK_CYC  = 6,
  parameter int FLASH_CYC = 4,
  parameter int CNT_W     = 4,
  parameter int SRV_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ped_btn,
  input  logic             veh_red,
  input  logic             veh_yellow,
  input  logic             veh_green,
  output logic             walk,
  output logic             dont_walk,
  output logic             req_pending,
  output logic [CNT_W-1:0] remaining,
  output logic             abort_p,
  output logic             fault,
  output logic [SRV_W-1:0] served
);
  typedef enum logic [2:0] {IDLE, WAIT, WALK, FLASH, CLEAR, FAULT} state_t;
  localparam logic [CNT_W-1:0] WALK_INIT  = CNT_W'(WALK_CYC - 1);
  localparam logic [CNT_W-1:0] FLASH_INIT = CNT_W'(FLASH_CYC - 1);
  state_t           state, state_n;
  logic             walk_n, dont_walk_n, req_pending_n, abort_p_n, fault_n;
  logic [CNT_W-1:0] remaining_n;
  logic [SRV_W-1:0] served_n;
  logic             red_only, yellow_only, green_only, illegal;
  assign red_only    = veh_red & ~veh_yellow & ~veh_green;
  assign yellow_only = ~veh_red & veh_yellow & ~veh_green;
  assign green_only  = ~veh_red & ~veh_yellow & veh_green;
  assign illegal     = ~(red_only | yellow_only | green_only);
  // next state and next registered outputs; lamps default to the safe steady DONT_WALK
  always_comb begin
    state_n       = state;
    walk_n        = 1'b0;
    dont_walk_n   = 1'b1;
    req_pending_n = req_pending;
    remaining_n   = '0;
    abort_p_n     = 1'b0;
    fault_n       = fault;
    served_n      = served;
    if (state != FAULT && illegal) begin
      state_n       = FAULT;
      fault_n       = 1'b1;
      req_pending_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_n       = ped_btn ? WAIT : IDLE;
          req_pending_n = ped_btn;
        end
        WAIT: if (red_only) begin
          state_n       = WALK;
          walk_n        = 1'b1;
          dont_walk_n   = 1'b0;
          remaining_n   = WALK_INIT;
          req_pending_n = 1'b0;
        end
        WALK: if (!red_only) begin
          state_n   = CLEAR;
          abort_p_n = 1'b1;
        end else if (remaining != '0) begin
          walk_n      = 1'b1;
          dont_walk_n = 1'b0;
          remaining_n = remaining - 1'b1;
        end else begin
          state_n     = FLASH;
          remaining_n = FLASH_INIT;
        end
        FLASH: begin
          req_pending_n = req_pending | ped_btn;
          if (!red_only) begin
            state_n   = CLEAR;
            abort_p_n = 1'b1;
          end else if (remaining != '0) begin
            dont_walk_n = ~dont_walk;
            remaining_n = remaining - 1'b1;
          end else begin
            state_n  = CLEAR;
            served_n = &served ? served : served + 1'b1;
          end
        end
        CLEAR: begin
          req_pending_n = req_pending | ped_btn;
          state_n       = (req_pending | ped_btn) ? WAIT : IDLE;
        end
        default: begin
          state_n     = FAULT;
          dont_walk_n = ~dont_walk;
        end
      endcase
    end
  end
  // state and output registers, async reset to the idle steady-DONT_WALK condition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      walk        <= 1'b0;
      dont_walk   <= 1'b1;
      req_pending <= 1'b0;
      remaining   <= '0;
      abort_p     <= 1'b0;
      fault       <= 1'b0;
      served      <= '0;
    end else begin
      state       <= state_n;
      walk        <= walk_n;
      dont_walk   <= dont_walk_n;
      req_pending <= req_pending_n;
      remaining   <= remaining_n;
      abort_p     <= abort_p_n;
      fault       <= fault_n;
      served      <= served_n;
    end
  end
endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// tb_ped_crossing_ctrl: directed checks of the pedestrian crossing sequencer
module tb_ped_crossing_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ped_btn = 1'b0;
  logic       veh_red = 1'b1, veh_yellow = 1'b0, veh_green = 1'b0;
  logic       walk, dont_walk, req_pending, abort_p, fault;
  logic [3:0] remaining;
  logic [7:0] served;
  logic       walk2, dont_walk2, req_pending2, abort_p2, fault2;
  logic [3:0] remaining2;
  logic [1:0] served2;
  int         checks = 0;
  int         errors = 0;
  ped_crossing_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ped_btn(ped_btn),
    .veh_red(veh_red), .veh_yellow(veh_yellow), .veh_green(veh_green),
    .walk(walk), .dont_walk(dont_walk), .req_pending(req_pending),
    .remaining(remaining), .abort_p(abort_p), .fault(fault), .served(served)
  );
  ped_crossing_ctrl #(.SRV_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ped_btn(ped_btn),
    .veh_red(veh_red), .veh_yellow(veh_yellow), .veh_green(veh_green),
    .walk(walk2), .dont_walk(dont_walk2), .req_pending(req_pending2),
    .remaining(remaining2), .abort_p(abort_p2), .fault(fault2), .served(served2)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic lamps(input logic r, input logic y, input logic g);
    veh_red = r;
    veh_yellow = y;
    veh_green = g;
  endtask
  task automatic crossing();
    ped_btn = 1'b1;
    tick();
    ped_btn = 1'b0;
    tick(1 + 5 + 1 + 4 + 1);
  endtask
  initial begin
    tick(2);
    check("rst_walk", walk, 0);
    check("rst_dw", dont_walk, 1);
    check("rst_req", req_pending, 0);
    check("rst_rem", remaining, 0);
    check("rst_abort", abort_p, 0);
    check("rst_fault", fault, 0);
    check("rst_served", served, 0);
    rst_n = 1'b1;
    tick();
    check("idle_dw", dont_walk, 1);
    ped_btn = 1'b1;
    tick();
    ped_btn = 1'b0;
    check("t1_wait_req", req_pending, 1);
    check("t1_wait_walk", walk, 0);
    tick();
    check("t1_walk", walk, 1);
    check("t1_walk_dw", dont_walk, 0);
    check("t1_walk_rem", remaining, 5);
    check("t1_walk_req", req_pending, 0);
    for (int i = 4; i >= 0; i--) begin
      tick();
      check("t1_walk_hold", walk, 1);
      check("t1_walk_nodw", dont_walk, 0);
      check("t1_walk_cnt", remaining, i);
    end
    tick();
    check("t1_flash_walk", walk, 0);
    check("t1_flash_dw0", dont_walk, 1);
    check("t1_flash_rem", remaining, 3);
    for (int i = 2; i >= 0; i--) begin
      tick();
      check("t1_flash_dw", dont_walk, i % 2 == 0 ? 0 : 1);
      check("t1_flash_cnt", remaining, i);
    end
    tick();
    check("t1_clear_dw", dont_walk, 1);
    check("t1_clear_rem", remaining, 0);
    check("t1_served", served, 1);
    tick();
    check("t1_idle_req", req_pending, 0);
    check("t1_idle_walk", walk, 0);
    lamps(0, 0, 1);
    ped_btn = 1'b1;
    tick();
    ped_btn = 1'b0;
    check("t2_req_green", req_pending, 1);
    tick();
    check("t2_req_g2", req_pending, 1);
    check("t2_walk_g2", walk, 0);
    lamps(0, 1, 0);
    tick();
    check("t2_req_y1", req_pending, 1);
    check("t2_walk_y1", walk, 0);
    tick();
    check("t2_req_y2", req_pending, 1);
    check("t2_walk_y2", walk, 0);
    lamps(1, 0, 0);
    tick();
    check("t2_walk_red", walk, 1);
    check("t2_req_red", req_pending, 0);
    tick(2);
    check("t3_rem3", remaining, 3);
    lamps(0, 0, 1);
    tick();
    check("t3_abort_walk", walk, 0);
    check("t3_abort_dw", dont_walk, 1);
    check("t3_abort_p", abort_p, 1);
    check("t3_abort_rem", remaining, 0);
    check("t3_served", served, 1);
    tick();
    check("t3_abort_1cyc", abort_p, 0);
    check("t3_fault", fault, 0);
    lamps(1, 0, 0);
    ped_btn = 1'b1;
    tick();
    ped_btn = 1'b0;
    tick();
    check("t4_walk", walk, 1);
    tick(6);
    check("t4_flash_rem", remaining, 3);
    ped_btn = 1'b1;
    tick();
    ped_btn = 1'b0;
    check("t4_flash_req", req_pending, 1);
    check("t4_flash_dw", dont_walk, 0);
    tick(3);
    check("t4_clear_served", served, 2);
    check("t4_clear_req", req_pending, 1);
    check("t4_clear_dw", dont_walk, 1);
    tick();
    check("t4_wait_walk", walk, 0);
    check("t4_wait_req", req_pending, 1);
    tick();
    check("t4_walk2", walk, 1);
    check("t4_walk2_rem", remaining, 5);
    tick(6 + 4);
    check("t4_served2", served, 3);
    tick();
    lamps(1, 0, 1);
    tick();
    check("t5_fault", fault, 1);
    check("t5_dw_a", dont_walk, 1);
    check("t5_walk", walk, 0);
    lamps(1, 0, 0);
    tick();
    check("t5_dw_b", dont_walk, 0);
    ped_btn = 1'b1;
    tick();
    ped_btn = 1'b0;
    check("t5_dw_c", dont_walk, 1);
    check("t5_btn_ign", req_pending, 0);
    check("t5_walk_ign", walk, 0);
    tick();
    check("t5_dw_d", dont_walk, 0);
    check("t5_sticky", fault, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_arst_fault", fault, 0);
    check("t5_arst_dw", dont_walk, 1);
    check("t5_arst_served", served, 0);
    check("t5_arst_req", req_pending, 0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) begin
      crossing();
      check("t6_served", served, i);
      check("t6_served_sat", served2, i > 3 ? 3 : i);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
